uart_tx_datapath: RTL and testbench
===================================

# uart_tx_datapath

Bit-level datapath of the UART transmitter. It sits directly downstream of the TX FSM and is driven by the FSM's `ser_en` and `mux_sel`. It captures the parallel byte, serializes it LSB-first, computes the parity bit, and drives the registered serial line `TX_OUT`. It returns `ser_done` to the FSM, which uses it to leave the data-bit phase.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; legal range 1..16.
- `CLK`  input  1  system clock, rising edge.
- `RST`  input  1  asynchronous, active-low reset.
- `P_DATA`  input  DATA_WIDTH  parallel byte; sampled only in the load cycle.
- `mux_sel`  input  2  line select from the FSM:
  - 00: start bit (0)
  - 01: stop/idle (1)
  - 10: serial data bit
  - 11: parity bit
- `ser_en`  input  1  shift enable from the FSM.
- `PAR_TYPE`  input  1  0 = even, 1 = odd; present only with `UART_TX_PAR_TYPE_EN`.
- `ser_done`  output  1  all DATA_WIDTH bits shifted out.
- `TX_OUT`  output  1  registered serial line.

## Operation
- **Internal registers:**
  - `shift_reg[DATA_WIDTH-1:0]`
  - `bit_cnt`, width clog2(DATA_WIDTH+1)
  - `par_bit`
- **Load cycle:** any cycle with `mux_sel`==00 (FSM start-bit cycle). At the ending edge:
  - `shift_reg` <= `P_DATA`
  - `bit_cnt` <= 0
  - `par_bit` <= ^`P_DATA` (even), or ~^`P_DATA` (odd)
  - `ser_en` is ignored in this cycle.
- **Shift cycle:** `ser_en`=1, `mux_sel`=10 and `bit_cnt`<DATA_WIDTH. At the edge:
  - `shift_reg` shifts right with 0 fill.
  - `bit_cnt` += 1.
- **Hold:** in all other cycles, `shift_reg`, `bit_cnt` and `par_bit` hold.
- **`ser_done`:** combinational, = (`bit_cnt`==DATA_WIDTH). It stays high until the next load; the FSM ignores it outside the data-bit phase.
- **Line mux (combinational):**
  - 00 -> 0
  - 01 -> 1
  - 10 -> `shift_reg[0]`
  - 11 -> `par_bit`
- **`TX_OUT`:** registered every edge from the mux output; glitch-free line.
- **Frame on the line, one bit per cycle:** start, D0..D(DATA_WIDTH-1), [parity], stop.
  - With parity, the bit after the last data bit comes from the cycle where `ser_done`=1 and the FSM drives 11. The stop bit follows from the FSM's parity state.
  - Without parity, the FSM drives 01 in the `ser_done` cycle, giving the stop bit directly.
- **Back-to-back frames:** the FSM drives 00 in its stop state when DATA_VALID is high. That is a normal load; no idle bit is inserted between frames.
- **Bad select:** `mux_sel`=10 while `bit_cnt`==DATA_WIDTH causes no shift and drives 0 on the line. This is a FSM protocol error; the bench flags it.

## Timing
- **Reset values:** `TX_OUT`=1, `ser_done`=0, `bit_cnt`=0, `shift_reg`=0, `par_bit`=0.
- **Reset mid-frame:** the line returns to 1 immediately (asynchronous). Nothing resumes; the next frame needs a new load.
- **`TX_OUT` latency:** exactly one cycle behind `mux_sel` for every bit type.
- **`ser_done` timing:** rises DATA_WIDTH edges after the load edge, i.e. in the (DATA_WIDTH+1)th cycle after the start-bit cycle.
- **Frame length on the line:** 1 + DATA_WIDTH + PAR_EN + 1 cycles.
- **Simultaneous load and `ser_done`=1 (stop state):** load wins. `ser_done` drops the cycle after the load edge.

## Configuration
- **`UART_TX_PAR_TYPE_EN` defined:** the `PAR_TYPE` port exists. `PAR_TYPE` is sampled in the load cycle, so a change mid-frame has no effect on the current frame.
- **Not defined:** the port is absent and parity is fixed even (`par_bit` = ^`P_DATA`).

## Test plan
- **Even parity:** DATA_WIDTH=8, `P_DATA`=A5, parity enabled -> `TX_OUT` from the cycle after start: 0,1,0,1,0,0,1,0,1,0,1. `ser_done` high 8 edges after load.
- **Odd parity:** `UART_TX_PAR_TYPE_EN`, `PAR_TYPE`=1, `P_DATA`=A5 -> parity bit 1, otherwise identical to the even-parity case.
- **No parity:** `P_DATA`=3C -> 0,0,0,1,1,1,1,0,0,1 (10 bits), then the line stays 1 while idle.
- **Back-to-back:** frames 55 then FF with DATA_VALID held, parity enabled -> 11-bit frames with no gap. The second start bit immediately follows the first stop bit; `ser_done` falls one cycle after the second load.
- **Reset mid-frame:** assert RST low during D3 of 0F -> `TX_OUT`=1 and `ser_done`=0 asynchronously. After release, frame 81 transmits correctly with parity 0.
- **Data stability:** change `P_DATA` every cycle after load -> the transmitted bits still match the value sampled in the load cycle.

Source files
------------

// File: rtl/uart_tx_datapath.sv
// -----------------------------------------------------------------------------
// uart_tx_datapath
//
// Bit-level datapath of the UART transmitter. It is steered by the TX FSM
// through mux_sel and ser_en. It captures the parallel word in the start-bit
// cycle and shifts it out LSB-first. It computes the parity bit, drives a
// registered (glitch-free) serial line, and tells the FSM when all data bits
// have been shifted out.
//
// Optional build macro:
//   UART_TX_PAR_TYPE_EN  - adds the PAR_TYPE port (0 = even, 1 = odd parity).
//                          Without it, parity is fixed to even.
//
// Ports:
//   CLK       in   1           system clock, rising edge
//   RST       in   1           asynchronous reset, active-low
//   P_DATA    in   DATA_WIDTH  parallel word, sampled only in the load cycle
//   mux_sel   in   2           line select: 00 start, 01 stop/idle,
//                              10 data bit, 11 parity bit
//   ser_en    in   1           shift enable from the FSM
//   PAR_TYPE  in   1           parity type (only with UART_TX_PAR_TYPE_EN)
//   ser_done  out  1           all DATA_WIDTH bits have been shifted out
//   TX_OUT    out  1           registered serial line
// -----------------------------------------------------------------------------
module uart_tx_datapath #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic [1:0]            mux_sel,
  input  logic                  ser_en,
`ifdef UART_TX_PAR_TYPE_EN
  input  logic                  PAR_TYPE,
`endif
  output logic                  ser_done,
  output logic                  TX_OUT
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_WIDTH);

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  // XOR-reduce gives even parity; inverting it gives odd parity.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic                  odd);
    return (^data) ^ odd;
  endfunction

  logic par_odd;
`ifdef UART_TX_PAR_TYPE_EN
  assign par_odd = PAR_TYPE;
`else
  assign par_odd = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  par_q,   par_d;
  logic                  tx_q;
  logic                  line_d;
  logic                  load;
  logic                  shift;

  // Load has priority over everything. This covers the back-to-back case
  // where the next start bit arrives while ser_done is still high.
  // A data select with the counter already full (an FSM protocol error)
  // does not shift.
  assign load  = (mux_sel == SEL_START);
  assign shift = ser_en && (mux_sel == SEL_DATA) && (cnt_q < CNT_FULL);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    if (load) begin
      shift_d = P_DATA;
      cnt_d   = '0;
      par_d   = calc_parity(P_DATA, par_odd);
    end else if (shift) begin
      shift_d = shift_q >> 1;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Line select. A data select after the last bit has been shifted
  // shows shift_q[0], which is 0 by then because of the zero fill.
  always_comb begin
    line_d = 1'b1;
    case (mux_sel)
      SEL_START: line_d = 1'b0;
      SEL_STOP:  line_d = 1'b1;
      SEL_DATA:  line_d = shift_q[0];
      SEL_PAR:   line_d = par_q;
      default:   line_d = 1'b1;
    endcase
  end

  // ---- register stage: shifter state and registered serial line ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx_q    <= line_d;
    end
  end

  assign ser_done = (cnt_q == CNT_FULL);
  assign TX_OUT   = tx_q;

endmodule

// File: tb/tb_uart_tx_datapath.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_datapath
//
// Self-checking bench for uart_tx_datapath. The bench acts as the TX FSM
// and drives mux_sel and ser_en cycle by cycle. It predicts each line bit
// from the frame definition: start 0, data LSB-first, optional parity
// (XOR of the data, inverted for odd), stop 1. TX_OUT is expected one
// cycle after the select that produced it.
// -----------------------------------------------------------------------------
module tb_uart_tx_datapath;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic [1:0]   mux_sel;
  logic         ser_en;
`ifdef UART_TX_PAR_TYPE_EN
  logic         PAR_TYPE;
`endif
  logic         ser_done;
  logic         TX_OUT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_tx_datapath #(.DATA_WIDTH(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .P_DATA   (P_DATA),
    .mux_sel  (mux_sel),
    .ser_en   (ser_en),
`ifdef UART_TX_PAR_TYPE_EN
    .PAR_TYPE (PAR_TYPE),
`endif
    .ser_done (ser_done),
    .TX_OUT   (TX_OUT)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one cycle of FSM outputs, then sample 1 time unit after the edge.
  task automatic step(input logic [1:0] sel, input logic en, input logic [W-1:0] pd);
    mux_sel = sel;
    ser_en  = en;
    P_DATA  = pd;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic ref_parity(input logic [W-1:0] d, input bit odd);
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) if (((d >> i) & 1) != 0) ones++;
    return 1'((ones % 2) ^ (odd ? 1 : 0));
  endfunction

  // One frame. P_DATA is scrambled in every cycle after the load cycle.
  // Random stalls (ser_en=0) and an optional bad select are inserted.
  task automatic send_frame(input logic [W-1:0] d, input bit pen, input bit pt,
                            input bit stalls, input bit bad);
    logic exp_par;
    int   idx;
`ifdef UART_TX_PAR_TYPE_EN
    PAR_TYPE = pt;
    exp_par  = ref_parity(d, pt);
`else
    exp_par  = ref_parity(d, 1'b0);
`endif
    step(2'b00, 1'($urandom_range(0, 1)), d);
    chk("start_bit", TX_OUT, 1'b0);
    chk("done_after_load", ser_done, 1'b0);
`ifdef UART_TX_PAR_TYPE_EN
    PAR_TYPE = ~pt;
`endif
    idx = 0;
    while (idx < W) begin
      if (stalls && $urandom_range(0, 3) == 0) begin
        step(2'b10, 1'b0, W'($urandom));
        chk("stall_bit", TX_OUT, 1'(d >> idx));
        chk("stall_done", ser_done, 1'b0);
      end else begin
        step(2'b10, 1'b1, W'($urandom));
        chk("data_bit", TX_OUT, 1'(d >> idx));
        idx++;
        chk("done_flag", ser_done, (idx == W) ? 1'b1 : 1'b0);
      end
    end
    if (bad) begin
      step(2'b10, 1'b1, W'($urandom));
      chk("bad_sel_line", TX_OUT, 1'b0);
      chk("bad_sel_done", ser_done, 1'b1);
    end
    if (pen) begin
      step(2'b11, 1'($urandom_range(0, 1)), W'($urandom));
      chk("parity_bit", TX_OUT, exp_par);
      chk("parity_done", ser_done, 1'b1);
    end
    step(2'b01, 1'b0, W'($urandom));
    chk("stop_bit", TX_OUT, 1'b1);
    chk("stop_done", ser_done, 1'b1);
  endtask

  initial begin
    RST     = 1'b0;
    mux_sel = 2'b01;
    ser_en  = 1'b0;
    P_DATA  = '0;
`ifdef UART_TX_PAR_TYPE_EN
    PAR_TYPE = 1'b0;
`endif
    #12;
    chk("reset_tx", TX_OUT, 1'b1);
    chk("reset_done", ser_done, 1'b0);
    RST = 1'b1;
    step(2'b01, 1'b0, '0);
    chk("idle_line", TX_OUT, 1'b1);
    chk("idle_done", ser_done, 1'b0);

    // Even parity, A5: parity bit 0.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef UART_TX_PAR_TYPE_EN
    // Odd parity, A5: parity bit 1.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    // No parity, 3C, then the line stays idle high.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 1'b0, W'($urandom));
      chk("idle_after_3c", TX_OUT, 1'b1);
    end

    // Back-to-back 55 then FF, no idle between frames.
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Bad select after the last data bit.
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame during D3 of 0F.
    step(2'b00, 1'b0, 8'h0F);
    for (int i = 0; i < 4; i++) step(2'b10, 1'b1, W'($urandom));
    chk("pre_reset_d3", TX_OUT, 1'b1);
    #2 RST = 1'b0;
    #1;
    chk("async_reset_tx", TX_OUT, 1'b1);
    chk("async_reset_done", ser_done, 1'b0);
    mux_sel = 2'b01;
    ser_en  = 1'b0;
    @(posedge CLK);
    #3 RST = 1'b1;
    step(2'b01, 1'b0, W'($urandom));
    chk("post_reset_line", TX_OUT, 1'b1);
    chk("post_reset_done", ser_done, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized frames with stalls, optional parity, random gaps.
    for (int f = 0; f < 30; f++) begin
      send_frame(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b1, ($urandom_range(0, 7) == 0));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        step(2'b01, 1'($urandom_range(0, 1)), W'($urandom));
        chk("rand_idle", TX_OUT, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
